baseerat_sr_update_scheduler: RTL

- Arbitrates stage-update requests from NUM_REQ independent requesters onto the single update/udin port pair of the M-stage shift register.
- Each requester names a target stage and data. The scheduler grants one request per cycle using round-robin.
- It drives a registered one-hot `update` vector and `udin` word straight into the shift register.
- It rejects out-of-range stage indices and supports a pause control.

---
 rtl/baseerat_sr_pkg.sv | 14 +
 rtl/baseerat_sr_update_scheduler_if.sv | 56 +++++
 rtl/baseerat_rr_arbiter.sv | 32 +++
 rtl/baseerat_sr_update_scheduler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/baseerat_sr_pkg.sv
// Shared constants and state encoding for the shift-register update scheduler.
// The optional grant statistics are enabled with BASEERAT_SR_UPD_STATS_EN.
package baseerat_sr_pkg;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_PIPELINE_STAGES = 32;
  localparam int STAT_W = 16;

  typedef logic [0:0] state_t;

  localparam state_t ST_RUN = 1'b0;
  localparam state_t ST_PAUSED = 1'b1;

endpackage

// File: rtl/baseerat_sr_update_scheduler_if.sv
// Requester/shift-register bundle of the update scheduler.
// Carries stat_clr/stat_grants only with BASEERAT_SR_UPD_STATS_EN.
interface baseerat_sr_update_scheduler_if
  import baseerat_sr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PIPELINE_STAGES = DEF_PIPELINE_STAGES,
  parameter int NUM_REQ = 4
);
  localparam int STAGE_W = $clog2(PIPELINE_STAGES);
  localparam int REQ_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*STAGE_W-1:0] req_stage;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic pause;
  logic [PIPELINE_STAGES-1:0] update;
  logic [DATA_WIDTH-1:0] udin;
  logic err_valid;
  logic [REQ_W-1:0] err_req_id;
  logic busy;
`ifdef BASEERAT_SR_UPD_STATS_EN
  logic stat_clr;
  logic [NUM_REQ*STAT_W-1:0] stat_grants;

  modport master (
    output req_valid, req_stage, req_data,
    output pause, stat_clr,
    input req_ready, update, udin,
    input err_valid, err_req_id, busy,
    input stat_grants
  );
  modport slave (
    input req_valid, req_stage, req_data,
    input pause, stat_clr,
    output req_ready, update, udin,
    output err_valid, err_req_id, busy,
    output stat_grants
  );
`else
  modport master (
    output req_valid, req_stage, req_data,
    output pause,
    input req_ready, update, udin,
    input err_valid, err_req_id, busy
  );
  modport slave (
    input req_valid, req_stage, req_data,
    input pause,
    output req_ready, update, udin,
    output err_valid, err_req_id, busy
  );
`endif

endinterface

// File: rtl/baseerat_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// No configuration macros.
module baseerat_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int REQ_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_W-1:0]   winner
);

  logic found;

  always_comb begin : arb
    int idx;
    idx = 0;
    grant = '0;
    winner = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        winner = REQ_W'(idx);
      end
    end
    if (en && found) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/baseerat_sr_update_scheduler.sv
// Round-robin scheduler driving the shift register update/udin pair.
// Per-requester grant counters are built with BASEERAT_SR_UPD_STATS_EN.
module baseerat_sr_update_scheduler
  import baseerat_sr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PIPELINE_STAGES = DEF_PIPELINE_STAGES,
  parameter int NUM_REQ = 4
) (
  input logic clock,
  input logic reset,
  baseerat_sr_update_scheduler_if.slave bus
);

  localparam int STAGE_W = $clog2(PIPELINE_STAGES);
  localparam int REQ_W = $clog2(NUM_REQ);
  localparam logic [PIPELINE_STAGES-1:0] ONE =
    {{(PIPELINE_STAGES-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [REQ_W-1:0] ptr_q, ptr_d;
  logic [PIPELINE_STAGES-1:0] update_q, update_d;
  logic [DATA_WIDTH-1:0] udin_q, udin_d;
  logic err_valid_q, err_valid_d;
  logic [REQ_W-1:0] err_id_q, err_id_d;

  logic grant_en;
  logic hs;
  logic in_range;
  logic [NUM_REQ-1:0] grant;
  logic [REQ_W-1:0] winner;
  logic [STAGE_W-1:0] sel_stage;
  logic [DATA_WIDTH-1:0] sel_data;

  assign grant_en = (state_q == ST_RUN) && !bus.pause;

  baseerat_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req_valid),
    .en     (grant_en),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  assign hs = |grant;
  assign sel_stage =
    bus.req_stage[int'(winner)*STAGE_W +: STAGE_W];
  assign sel_data =
    bus.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign in_range = int'(sel_stage) < PIPELINE_STAGES;

  always_comb begin
    state_d = bus.pause ? ST_PAUSED : ST_RUN;
    ptr_d = ptr_q;
    update_d = '0;
    udin_d = udin_q;
    err_valid_d = 1'b0;
    err_id_d = err_id_q;
    if (hs) begin
      ptr_d = (winner == REQ_W'(NUM_REQ-1)) ?
              '0 : winner + REQ_W'(1);
      // Bad stages still consume the turn but never touch udin.
      if (in_range) begin
        update_d = ONE << sel_stage;
        udin_d = sel_data;
      end else begin
        err_valid_d = 1'b1;
        err_id_d = winner;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      ptr_q <= '0;
      update_q <= '0;
      udin_q <= '0;
      err_valid_q <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      update_q <= update_d;
      udin_q <= udin_d;
      err_valid_q <= err_valid_d;
      err_id_q <= err_id_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.update = update_q;
  assign bus.udin = udin_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_req_id = err_id_q;
  assign bus.busy = (state_q == ST_PAUSED) || (|update_q);

`ifdef BASEERAT_SR_UPD_STATS_EN
  logic [NUM_REQ*STAT_W-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.stat_clr)
        stat_d[i*STAT_W +: STAT_W] = '0;
      else if (grant[i] && stat_q[i*STAT_W +: STAT_W] != '1)
        stat_d[i*STAT_W +: STAT_W] =
          stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stat_q <= '0;
    else stat_q <= stat_d;
  end

  assign bus.stat_grants = stat_q;
`endif

endmodule
